// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bridge: I/O page, register offsets and the
// register-select decode used by the read mux and store strobes.
package mmio_pkg;

    localparam logic [19:0] IO_PAGE = 20'hFFFFF;

    localparam logic [11:0] OFF_CNT     = 12'h020;
    localparam logic [11:0] OFF_LED     = 12'h060;
    localparam logic [11:0] OFF_SW      = 12'h070;
    localparam logic [11:0] OFF_BTN     = 12'h078;
    localparam logic [11:0] OFF_BTN_EVT = 12'h07C;

    localparam int DEB_CYCLES_DEFAULT = 1000000;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CNT,
        REG_LED,
        REG_SW,
        REG_BTN,
        REG_BTN_EVT
    } reg_sel_t;

    function automatic reg_sel_t decode_offset(input logic [11:0] offset);
        reg_sel_t sel;
        case (offset)
            OFF_CNT:     sel = REG_CNT;
            OFF_LED:     sel = REG_LED;
            OFF_SW:      sel = REG_SW;
            OFF_BTN:     sel = REG_BTN;
            OFF_BTN_EVT: sel = REG_BTN_EVT;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_bridge_io_debounce.sv
// Two-flop synchroniser followed by a whole-bank stability counter; the
// debounced value only follows the pins after DEB_CYCLES quiet cycles.
module io_debounce
    import mmio_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    stable_cnt;
    logic             changed;

    assign changed = (sync2 != prev);

    // A change on the same cycle the counter is saturated must not leak into deb.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            deb        <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            if (changed) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
            if (!changed && stable_cnt == CNT_MAX) begin
                deb <= sync2;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-port decoder: routes accesses to RAM or the I/O page and hosts the
// cycle counter, LED strobe, debounced switch/button readback and button events.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int SW_W       = 24,
    parameter int BTN_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              dram_we,
    input  logic [31:0]       dram_rdata,
    output logic              led_wen,
    output logic [31:0]       led_wdata,
    input  logic [23:0]       led_state,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [BTN_W-1:0]  btn_raw
);

    logic             io_hit;
    logic [11:0]      offset;
    reg_sel_t         sel;
    logic [SW_W-1:0]  deb_sw;
    logic [BTN_W-1:0] deb_btn;
    logic [BTN_W-1:0] deb_btn_q;
    logic [BTN_W-1:0] btn_rise;
    logic [BTN_W-1:0] btn_clr;
    logic [BTN_W-1:0] btn_evt;
    logic [31:0]      cnt;

    assign io_hit    = (cpu_addr[31:12] == IO_PAGE);
    assign offset    = cpu_addr[11:0];
    assign sel       = io_hit ? decode_offset(offset) : REG_NONE;
    assign dram_we   = cpu_we & ~io_hit;
    assign led_wen   = cpu_we & (sel == REG_LED);
    assign led_wdata = cpu_wdata;

    io_debounce #(.WIDTH(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk (clk),
        .rst (rst),
        .raw (sw_raw),
        .deb (deb_sw)
    );

    io_debounce #(.WIDTH(BTN_W), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk (clk),
        .rst (rst),
        .raw (btn_raw),
        .deb (deb_btn)
    );

    assign btn_rise = deb_btn & ~deb_btn_q;
    assign btn_clr  = (cpu_we && sel == REG_BTN_EVT) ? cpu_wdata[BTN_W-1:0] : '0;

    // Set is OR-ed in after the clear so a coincident press survives a W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            deb_btn_q <= '0;
            btn_evt   <= '0;
        end else begin
            if (cpu_we && sel == REG_CNT) begin
                cnt <= cpu_wdata;
            end else begin
                cnt <= cnt + 32'd1;
            end
            deb_btn_q <= deb_btn;
            btn_evt   <= (btn_evt & ~btn_clr) | btn_rise;
        end
    end

    // I/O reads are forced to zero while reset is held, RAM reads are not.
    always_comb begin
        cpu_rdata = '0;
        if (!io_hit) begin
            cpu_rdata = dram_rdata;
        end else if (!rst) begin
            case (sel)
                REG_CNT:     cpu_rdata = cnt;
                REG_LED:     cpu_rdata = {8'h00, led_state};
                REG_SW:      cpu_rdata = 32'(deb_sw);
                REG_BTN:     cpu_rdata = 32'(deb_btn);
                REG_BTN_EVT: cpu_rdata = 32'(btn_evt);
                default:     cpu_rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Address decoder and peripheral register block between the CPU data-memory port and the board I/O.
- Routes each CPU load/store either to data RAM or to the I/O page 0xFFFFF000–0xFFFFFFFF.
- Generates the LED write strobe consumed by the LED register stage.
- Owns the switch/button synchronisers, the debouncers, a sticky button-event register and a free-running cycle counter.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles required before a debounced input updates. Minimum 2; benches override to 4.
- SW_W, 24: switch bank width.
- BTN_W, 5: button bank width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address of the current data access.
- cpu_we  in  1  store strobe.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data returned to the CPU.
- dram_we  out  1  RAM write enable.
- dram_rdata  in  32  RAM read data.
- led_wen  out  1  LED register write strobe.
- led_wdata  out  32  LED register write data.
- led_state  in  24  current LED register value, used for readback.
- sw_raw  in  SW_W  asynchronous switch pins.
- btn_raw  in  BTN_W  asynchronous button pins.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Decode (combinational):
  - io_hit = (cpu_addr[31:12] == 20'hFFFFF); offset = cpu_addr[11:0].
  - dram_we = cpu_we & ~io_hit.
  - led_wen = cpu_we & io_hit & (offset == 0x060).
  - led_wdata = cpu_wdata, always passed through.
- Register map (offsets):
  - 0x020 CNT: R/W.
  - 0x060 LED: R/W; read = {8'h0, led_state}.
  - 0x070 SW: RO; read = zero-extended debounced switches.
  - 0x078 BTN: RO; read = zero-extended debounced buttons.
  - 0x07C BTN_EVT: read = sticky press flags; write-1-to-clear.
- Reads: cpu_rdata = dram_rdata when ~io_hit. Unmapped I/O offsets read 32'h0; stores to them are ignored with no side effects. Loads have no side effects.
- Synchroniser: 2-flop chain per bit for sw_raw and btn_raw. Both stages reset to 0.
- Debounce, per bank:
  - stable_cnt clears to 0 whenever the synchronised value differs from its previous-cycle value.
  - Otherwise stable_cnt increments, saturating at DEB_CYCLES-1.
  - When stable_cnt == DEB_CYCLES-1, deb <= synchronised value.
  - Latency from a clean raw edge to the deb update is 2 + DEB_CYCLES cycles (±1 for input sampling phase).
  - A glitch shorter than DEB_CYCLES never reaches deb.
  - Reset: deb = 0, stable_cnt = 0.
- Button events:
  - btn_evt[i] is set on the cycle after deb_btn[i] rises 0->1.
  - A store to BTN_EVT clears the bits where cpu_wdata is 1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Reset value 0.
- Cycle counter:
  - cnt increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A store to CNT loads cpu_wdata, taking priority over the increment; increments resume the following cycle.
  - Reset value 0.
- Outputs under reset: cpu_rdata still follows the decode mux. While rst is high all registers read as 0; led_wen and dram_we remain purely combinational from cpu_*.
- Reset asserted mid-debounce discards any partial count; reset asserted during a store suppresses the register update but not the led_wen/dram_we strobes.

Decomposition:
- Shared package mmio_pkg holds:
  - IO_PAGE = 20'hFFFFF.
  - Offset constants OFF_CNT, OFF_LED, OFF_SW, OFF_BTN, OFF_BTN_EVT.
  - Default DEB_CYCLES.
- One sub-module, io_debounce (parameters WIDTH and DEB_CYCLES): contains the 2-flop synchroniser, stable counter and deb register. Instantiated twice, once for switches and once for buttons.
- Event logic, counter and decode stay in mmio_bridge.

Test Plan (DEB_CYCLES = 4):
- Reset: hold rst 3 cycles with sw_raw = 24'hFFFFFF. Loads of CNT, SW, BTN and BTN_EVT return 0 during reset; SW reads 0x00FFFFFF only after 6+ cycles of rst low.
- LED path: store 0xFFFFF060 <- 0x00A5A5A5 -> led_wen = 1 for exactly that cycle, dram_we = 0, led_wdata = 0x00A5A5A5. Store to 0x00001000 -> dram_we = 1, led_wen = 0.
- Debounce: toggle sw_raw[0] for 3 cycles then release -> SW stays 0. Hold sw_raw[0] = 1 -> SW reads 0x1 after 6 cycles (±1).
- Button event: press btn_raw[2] -> BTN_EVT = 0x4 once debounced. Store 0x4 to BTN_EVT in the same cycle as a btn[2] rising edge -> flag stays set. Plain store of 0x4 -> reads 0.
- Counter: store CNT <- 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0 on consecutive cycles.
- Unmapped: load 0xFFFFF100 -> 0. Store 0xFFFFF100 -> no led_wen, no dram_we, no register change.
